// File: rtl/cam_frame_capture.sv
// Camera-side frame buffer writer: synchronises an RGB444 byte stream, assembles
// 12-bit pixels, decimates the sensor frame and writes kept pixels linearly.
module cam_frame_capture #(
  parameter int c_img_cols    = 80,
  parameter int c_img_rows    = 60,
  parameter int c_img_pxls    = c_img_cols * c_img_rows,
  parameter int c_nb_img_pxls = 13,
  parameter int c_cam_cols    = 640,
  parameter int c_cam_rows    = 480,
  parameter int c_dec_log2    = 3,
  parameter int c_nb_buf      = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     capture_en,
  input  logic                     cam_pclk,
  input  logic                     cam_vsync,
  input  logic                     cam_href,
  input  logic [7:0]               cam_data,
  output logic                     wr_en,
  output logic [c_nb_img_pxls-1:0] wr_addr,
  output logic [c_nb_buf-1:0]      wr_pxl,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     frame_err
);

  localparam int c_nb_col = $clog2(c_cam_cols + 1);
  localparam int c_nb_row = $clog2(c_cam_rows + 1);
  localparam int c_nb_cnt = $clog2(c_img_pxls + 1);

  localparam logic [c_nb_col-1:0] c_col_max = c_nb_col'(c_cam_cols);
  localparam logic [c_nb_row-1:0] c_row_max = c_nb_row'(c_cam_rows);
  localparam logic [c_nb_cnt-1:0] c_cnt_max = c_nb_cnt'(c_img_pxls);
  localparam logic [c_nb_col-1:0] c_col_one = c_nb_col'(1);
  localparam logic [c_nb_row-1:0] c_row_one = c_nb_row'(1);
  localparam logic [c_nb_cnt-1:0] c_cnt_one = c_nb_cnt'(1);

  typedef enum logic [1:0] {
    st_idle     = 2'd0,
    st_wait_sof = 2'd1,
    st_frame    = 2'd2
  } state_t;

  state_t state_r, next_state_s;

  logic       pclk_s1_r, pclk_s2_r, pclk_s3_r;
  logic       vsync_s1_r, vsync_s2_r, vsync_s3_r;
  logic       href_s1_r, href_s2_r, href_s3_r;
  logic [7:0] data_s1_r, data_s2_r;

  logic                pclk_rise_s, vs_rise_s, vs_fall_s, href_fall_s;
  logic                clear_s, in_frame_s, eof_s, byte_s, line_end_s;
  logic                dec_hit_s, in_range_s, keep_s, done_s, err_s;
  logic [c_nb_buf-1:0] pixel_s;

  logic                phase_r;
  logic [3:0]          r_hold_r;
  logic [c_nb_col-1:0] cam_col_r;
  logic [c_nb_row-1:0] cam_row_r;
  logic [c_nb_cnt-1:0] wr_cnt_r;

  logic                     wr_en_r;
  logic [c_nb_img_pxls-1:0] wr_addr_r;
  logic [c_nb_buf-1:0]      wr_pxl_r;
  logic                     busy_r, frame_done_r, frame_err_r;

  // Two-stage synchroniser plus edge-history stage for all camera inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pclk_s1_r  <= 1'b0;
      pclk_s2_r  <= 1'b0;
      pclk_s3_r  <= 1'b0;
      vsync_s1_r <= 1'b0;
      vsync_s2_r <= 1'b0;
      vsync_s3_r <= 1'b0;
      href_s1_r  <= 1'b0;
      href_s2_r  <= 1'b0;
      href_s3_r  <= 1'b0;
      data_s1_r  <= 8'h00;
      data_s2_r  <= 8'h00;
    end else begin
      pclk_s1_r  <= cam_pclk;
      pclk_s2_r  <= pclk_s1_r;
      pclk_s3_r  <= pclk_s2_r;
      vsync_s1_r <= cam_vsync;
      vsync_s2_r <= vsync_s1_r;
      vsync_s3_r <= vsync_s2_r;
      href_s1_r  <= cam_href;
      href_s2_r  <= href_s1_r;
      href_s3_r  <= href_s2_r;
      data_s1_r  <= cam_data;
      data_s2_r  <= data_s1_r;
    end
  end

  assign pclk_rise_s = pclk_s2_r & ~pclk_s3_r;
  assign vs_rise_s   = vsync_s2_r & ~vsync_s3_r;
  assign vs_fall_s   = ~vsync_s2_r & vsync_s3_r;
  assign href_fall_s = ~href_s2_r & href_s3_r;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= st_idle;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; capture_en only matters when idle or at end of frame
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      st_idle: begin
        if (capture_en) next_state_s = st_wait_sof;
        else            next_state_s = st_idle;
      end
      st_wait_sof: begin
        if (vs_fall_s) next_state_s = st_frame;
        else           next_state_s = st_wait_sof;
      end
      st_frame: begin
        if (vs_rise_s) begin
          if (capture_en) next_state_s = st_wait_sof;
          else            next_state_s = st_idle;
        end else begin
          next_state_s = st_frame;
        end
      end
      default: next_state_s = st_idle;
    endcase
  end

  // FSM output decode: counter clear on WAIT_SOF entry, byte/line/keep strobes
  always_comb begin
    clear_s    = 1'b0;
    in_frame_s = 1'b0;
    case (state_r)
      st_idle: begin
        clear_s    = capture_en;
        in_frame_s = 1'b0;
      end
      st_wait_sof: begin
        clear_s    = 1'b0;
        in_frame_s = 1'b0;
      end
      st_frame: begin
        clear_s    = vs_rise_s & capture_en;
        in_frame_s = 1'b1;
      end
      default: begin
        clear_s    = 1'b0;
        in_frame_s = 1'b0;
      end
    endcase

    eof_s      = in_frame_s & vs_rise_s;
    byte_s     = in_frame_s & ~vs_rise_s & href_s2_r & pclk_rise_s;
    line_end_s = in_frame_s & ~vs_rise_s & href_fall_s;
    dec_hit_s  = (cam_col_r[c_dec_log2-1:0] == {c_dec_log2{1'b0}}) &&
                 (cam_row_r[c_dec_log2-1:0] == {c_dec_log2{1'b0}});
    in_range_s = (cam_col_r < c_col_max) && (cam_row_r < c_row_max) &&
                 (wr_cnt_r < c_cnt_max);
    keep_s     = byte_s & phase_r & dec_hit_s & in_range_s;
    done_s     = eof_s & (wr_cnt_r == c_cnt_max);
    err_s      = eof_s & (wr_cnt_r != c_cnt_max);
    pixel_s    = c_nb_buf'({r_hold_r, data_s2_r});
  end

  // Byte phase, red-nibble hold and saturating sensor position counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_r   <= 1'b0;
      r_hold_r  <= 4'h0;
      cam_col_r <= {c_nb_col{1'b0}};
      cam_row_r <= {c_nb_row{1'b0}};
    end else if (clear_s) begin
      phase_r   <= 1'b0;
      cam_col_r <= {c_nb_col{1'b0}};
      cam_row_r <= {c_nb_row{1'b0}};
    end else if (line_end_s) begin
      phase_r   <= 1'b0;
      cam_col_r <= {c_nb_col{1'b0}};
      if (cam_row_r != c_row_max) cam_row_r <= cam_row_r + c_row_one;
    end else if (byte_s) begin
      if (!phase_r) begin
        r_hold_r <= data_s2_r[3:0];
        phase_r  <= 1'b1;
      end else begin
        phase_r <= 1'b0;
        if (cam_col_r != c_col_max) cam_col_r <= cam_col_r + c_col_one;
      end
    end
  end

  // Write count doubles as the linear buffer address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_r <= {c_nb_cnt{1'b0}};
    end else if (clear_s) begin
      wr_cnt_r <= {c_nb_cnt{1'b0}};
    end else if (keep_s) begin
      wr_cnt_r <= wr_cnt_r + c_cnt_one;
    end
  end

  // Registered outputs; address and data hold between writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_r      <= 1'b0;
      wr_addr_r    <= {c_nb_img_pxls{1'b0}};
      wr_pxl_r     <= {c_nb_buf{1'b0}};
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      wr_en_r      <= keep_s;
      busy_r       <= (next_state_s == st_frame);
      frame_done_r <= done_s;
      frame_err_r  <= err_s;
      if (clear_s) begin
        wr_addr_r <= {c_nb_img_pxls{1'b0}};
      end else if (keep_s) begin
        wr_addr_r <= c_nb_img_pxls'(wr_cnt_r);
        wr_pxl_r  <= pixel_s;
      end
    end
  end

  assign wr_en      = wr_en_r;
  assign wr_addr    = wr_addr_r;
  assign wr_pxl     = wr_pxl_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign frame_err  = frame_err_r;

endmodule

// File: tb/tb_cam_frame_capture.sv
// Directed bench for cam_frame_capture on a scaled sensor (32x16, decimation 4,
// 8x4 buffer); camera bytes follow pixel(c,r) = {c[3:0], r[3:0], (c^r)[3:0]}.
module tb_cam_frame_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        capture_en = 1'b0;
  logic        cam_pclk = 1'b0;
  logic        cam_vsync = 1'b1;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = 8'h00;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [11:0] wr_pxl;
  logic        busy, frame_done, frame_err;

  int errors = 0;
  int checks = 0;

  int          n_wr = 0;
  int          n_done = 0;
  int          n_err = 0;
  logic [4:0]  wa [0:1023];
  logic [11:0] wp [0:1023];

  cam_frame_capture #(
    .c_img_cols(8), .c_img_rows(4), .c_nb_img_pxls(5),
    .c_cam_cols(32), .c_cam_rows(16), .c_dec_log2(2), .c_nb_buf(12)
  ) dut (
    .clk(clk), .rst(rst), .capture_en(capture_en),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_pxl(wr_pxl),
    .busy(busy), .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Record every write and pulse, sampled away from the active edge
  always @(negedge clk) begin
    if (wr_en === 1'b1 && n_wr < 1024) begin
      wa[n_wr] <= wr_addr;
      wp[n_wr] <= wr_pxl;
      n_wr     <= n_wr + 1;
    end
    if (frame_done === 1'b1) n_done <= n_done + 1;
    if (frame_err === 1'b1)  n_err  <= n_err + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] pat(input int k);
    logic [31:0] c, r;
    c = 32'(4 * (k % 8));
    r = 32'(4 * (k / 8));
    return {c[3:0], r[3:0], c[3:0] ^ r[3:0]};
  endfunction

  task automatic pclk_cycle(input logic [7:0] d, input logic h);
    #20 cam_pclk = 1'b0;
    cam_data = d;
    cam_href = h;
    #20 cam_pclk = 1'b1;
  endtask

  task automatic cam_frame(input int rows, input int cols, input bit special,
                           input int en_row, input logic en_val, input int rst_row);
    logic [31:0] cv, rv;
    logic [7:0]  b0, b1;
    cam_vsync = 1'b1;
    repeat (4) pclk_cycle(8'h00, 1'b0);
    cam_vsync = 1'b0;
    repeat (4) pclk_cycle(8'h00, 1'b0);
    for (int r = 0; r < rows; r++) begin
      if (r == en_row) capture_en = en_val;
      if (r == rst_row) begin
        chk("busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        #3;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_pxl", 32'(wr_pxl), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done_err", 32'({frame_done, frame_err}), 32'd0);
        #37 rst = 1'b0;
      end
      rv = 32'(r);
      for (int c = 0; c < cols; c++) begin
        cv = 32'(c);
        b0 = {4'h5, cv[3:0]};
        b1 = {rv[3:0], cv[3:0] ^ rv[3:0]};
        if (special && r == 0 && c == 0) begin
          b0 = 8'h0A;
          b1 = 8'h5C;
        end
        pclk_cycle(b0, 1'b1);
        pclk_cycle(b1, 1'b1);
      end
      repeat (4) pclk_cycle(8'h00, 1'b0);
    end
    cam_vsync = 1'b1;
    repeat (4) pclk_cycle(8'h00, 1'b0);
  endtask

  task automatic check_frame(input string tag, input int bw, input int bd, input int be,
                             input int n_exp, input int exp_done, input int exp_err);
    chk({tag, "_count"}, 32'(n_wr - bw), 32'(n_exp));
    for (int k = 0; k < n_exp; k++) begin
      chk({tag, "_addr"}, 32'(wa[bw + k]), 32'(k));
      chk({tag, "_pxl"}, 32'(wp[bw + k]), 32'(pat(k)));
    end
    chk({tag, "_done"}, 32'(n_done - bd), 32'(exp_done));
    chk({tag, "_err"}, 32'(n_err - be), 32'(exp_err));
  endtask

  initial begin
    int bw, bd, be;

    // Reset held while the camera streams with capture enabled
    capture_en = 1'b1;
    cam_frame(4, 32, 1'b0, -1, 1'b0, -1);
    chk("reset_wr_en", 32'(wr_en), 32'd0);
    chk("reset_wr_addr", 32'(wr_addr), 32'd0);
    chk("reset_wr_pxl", 32'(wr_pxl), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_pulses", 32'(n_done + n_err), 32'd0);
    chk("reset_writes", 32'(n_wr), 32'd0);

    // Released with capture disabled: two frames, nothing happens
    rst = 1'b0;
    capture_en = 1'b0;
    bw = n_wr; bd = n_done; be = n_err;
    cam_frame(16, 32, 1'b0, -1, 1'b0, -1);
    cam_frame(16, 32, 1'b0, -1, 1'b0, -1);
    chk("disabled_writes", 32'(n_wr - bw), 32'd0);
    chk("disabled_pulses", 32'((n_done - bd) + (n_err - be)), 32'd0);
    chk("disabled_busy", 32'(busy), 32'd0);

    // Byte assembly on a one-line frame: 8 writes, then error pulse
    capture_en = 1'b1;
    bw = n_wr; bd = n_done; be = n_err;
    cam_frame(1, 32, 1'b1, -1, 1'b0, -1);
    chk("asm_count", 32'(n_wr - bw), 32'd8);
    chk("asm_first_addr", 32'(wa[bw]), 32'd0);
    chk("asm_first_pxl", 32'(wp[bw]), 32'h0A5C);
    chk("asm_second_pxl", 32'(wp[bw + 1]), 32'h0404);
    chk("asm_last_addr", 32'(wa[bw + 7]), 32'd7);
    chk("asm_done", 32'(n_done - bd), 32'd0);
    chk("asm_err", 32'(n_err - be), 32'd1);

    bw = n_wr; bd = n_done; be = n_err;
    cam_frame(16, 32, 1'b0, -1, 1'b0, -1);
    check_frame("full1", bw, bd, be, 32, 1, 0);

    bw = n_wr; bd = n_done; be = n_err;
    cam_frame(8, 32, 1'b0, -1, 1'b0, -1);
    check_frame("short", bw, bd, be, 16, 0, 1);

    bw = n_wr; bd = n_done; be = n_err;
    cam_frame(16, 32, 1'b0, -1, 1'b0, -1);
    check_frame("full2", bw, bd, be, 32, 1, 0);

    // Oversize lines/rows; capture_en dropped mid-frame must not abort it
    bw = n_wr; bd = n_done; be = n_err;
    cam_frame(20, 40, 1'b0, 10, 1'b0, -1);
    check_frame("oversize", bw, bd, be, 32, 1, 0);
    chk("oversize_idle_busy", 32'(busy), 32'd0);

    // Enable raised mid-frame: that frame is skipped entirely
    bw = n_wr; bd = n_done; be = n_err;
    cam_frame(16, 32, 1'b0, 6, 1'b1, -1);
    chk("midena_writes", 32'(n_wr - bw), 32'd0);
    chk("midena_pulses", 32'((n_done - bd) + (n_err - be)), 32'd0);

    bw = n_wr; bd = n_done; be = n_err;
    cam_frame(16, 32, 1'b0, -1, 1'b0, -1);
    check_frame("after_ena", bw, bd, be, 32, 1, 0);

    // Reset pulsed at row 8: rows 0 and 4 already written, rest abandoned
    bw = n_wr; bd = n_done; be = n_err;
    cam_frame(16, 32, 1'b0, -1, 1'b0, 8);
    chk("rstframe_writes", 32'(n_wr - bw), 32'd16);
    chk("rstframe_pulses", 32'((n_done - bd) + (n_err - be)), 32'd0);

    bw = n_wr; bd = n_done; be = n_err;
    cam_frame(16, 32, 1'b0, -1, 1'b0, -1);
    check_frame("after_rst", bw, bd, be, 32, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cam_frame_capture.md
# cam_frame_capture

Camera-side writer for the original-image frame buffer. Receives an OV7670-style RGB444 pixel stream (pclk/vsync/href/8-bit data), assembles 12-bit pixels, decimates the 640x480 sensor frame to 80x60, and writes each kept pixel into the buffer memory. The color-processing stage later reads that memory by address. Resolution and decimation are parameters, so the same block serves the QQVGA/2 and larger buffer configurations.

## Interface
- c_img_cols, 80, buffer image columns
- c_img_rows, 60, buffer image rows
- c_img_pxls, c_img_cols*c_img_rows, buffer pixels
- c_nb_img_pxls, 13, buffer address width
- c_cam_cols, 640, sensor pixels per line
- c_cam_rows, 480, sensor lines per frame
- c_dec_log2, 3, log2 of the decimation factor in both axes; 2^3 = 8
- c_nb_buf, 12, buffer word width; red [11:8], green [7:4], blue [3:0]
- clk  in  1  system clock; must be at least 4x cam_pclk
- rst  in  1  reset, asynchronous, active-high
- capture_en  in  1  level; high = capture frames continuously
- cam_pclk  in  1  camera pixel clock, asynchronous to clk
- cam_vsync  in  1  camera vsync; high during vertical blanking
- cam_href  in  1  camera line valid
- cam_data  in  8  camera byte, valid at cam_pclk rising edge
- wr_en  out  1  buffer write strobe; one clk per pixel
- wr_addr  out  c_nb_img_pxls  buffer write address
- wr_pxl  out  c_nb_buf  buffer write data {R,G,B}
- busy  out  1  high while in state FRAME
- frame_done  out  1  1-clk pulse: complete frame written
- frame_err  out  1  1-clk pulse: frame ended with a wrong write count

## Operation
- **Input synchronisation:** cam_pclk, cam_vsync, cam_href and cam_data pass through the same 2-FF synchroniser (s1, s2) plus one history FF (s3).
  - pclk_rise = pclk_s2 & ~pclk_s3.
  - vs_rise and vs_fall are detected the same way.
  - href_fall = ~href_s2 & href_s3.
  - Data is taken from data_s2, so it stays aligned with pclk_s2.
- **FSM states:** IDLE, WAIT_SOF, FRAME.
  - IDLE: move to WAIT_SOF when capture_en = 1.
  - WAIT_SOF: move to FRAME on vs_fall (start of frame). At entry, clear the counters: cam_col, cam_row, byte phase, wr_addr, write count.
  - FRAME, on vs_rise (end of frame):
    - write count == c_img_pxls: pulse frame_done.
    - otherwise: pulse frame_err.
    - next state is WAIT_SOF if capture_en = 1, else IDLE.
  - capture_en falling mid-frame does not abort the frame. It is only sampled at end of frame.
- **Byte assembly (FRAME, href_s2 = 1, pclk_rise):**
  - Phase 0: r_hold <= data[3:0]; phase <= 1.
  - Phase 1: pixel = {r_hold, data[7:4], data[3:0]}; phase <= 0; cam_col++ (saturates at c_cam_cols).
- **Line end:** on href_fall, set cam_col = 0, phase = 0, and cam_row++ (saturates at c_cam_rows).
- **Keep rule:** a pixel is kept if all of the following hold:
  - cam_col[c_dec_log2-1:0] == 0 and cam_row[c_dec_log2-1:0] == 0;
  - cam_col < c_cam_cols and cam_row < c_cam_rows;
  - write count < c_img_pxls.
  - Extra pixels or lines from the sensor are dropped silently.
- **Kept-pixel write:**
  - wr_en = 1 for one clk, with wr_pxl = pixel and wr_addr = current address.
  - The address then increments. It is linear (row*c_img_cols + col), generated by the counter alone; no multiplier.
- vsync or href activity in IDLE is ignored.
- **Reset values:**
  - All outputs 0: wr_en, wr_addr, wr_pxl, busy, frame_done, frame_err.
  - State IDLE; all counters and synchroniser FFs 0.
  - Reset mid-frame abandons the frame. Capture restarts at the next vs_fall after capture_en is seen.

## Timing
- **Write latency:** wr_en is high during the cycle after the 3rd clk rising edge following the edge at which cam_pclk (second byte) is first sampled high.
  - Edges 1–2: sync.
  - Edge 3: assembly/register.
- wr_addr/wr_pxl are valid only while wr_en = 1. Between writes they hold their last values.
- Consecutive writes are at least 8 cam_pclk periods apart at decimation 8, so there is no back-pressure.
- frame_done/frame_err assert 3 clk after vsync rise reaches s1 and are mutually exclusive.
- busy falls in the same cycle the done/err pulse is high.
- wr_addr wraps to 0 only at the next WAIT_SOF entry; it never exceeds c_img_pxls-1.

## Test plan
- Reset: assert rst with the camera toggling → all outputs 0, no wr_en; deassert with capture_en = 0 → no writes for 2 frames.
- Byte assembly: one line whose first pixel bytes are 0x0A, 0x5C → first write wr_pxl = 0xA5C, wr_addr = 0.
- Full frame, 640x480, pixel(c,r) = {c[3:0], r[3:0], (c^r)[3:0]}:
  - exactly 4800 writes, addresses 0..4799 in order;
  - write at address a carries pixel(8*(a%80), 8*(a/80));
  - one frame_done pulse, no frame_err.
- Short frame, 240 lines → 2400 writes; frame_err pulses, frame_done stays 0. Next full frame → 4800 writes starting at address 0.
- Oversize frame, lines of 700 pixels, 500 lines → still 4800 writes with the same addresses; frame_done pulses.
- capture_en raised mid-frame → no writes until the following vs_fall, then a full frame.
- rst pulsed during row 30 → outputs 0 at once; the next frame restarts at address 0 with 4800 writes.
